// File: rtl/alu_byte_sequencer.sv
// Byte-serial sequencer: runs an NBYTES-wide operation through one shared 8-bit ALU,
// least-significant byte first, chaining the carry between bytes in a register.
module alu_byte_sequencer #(
  parameter int NBYTES = 4,
  parameter int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [8*NBYTES-1:0]   cmd_a,
  input  logic [8*NBYTES-1:0]   cmd_b,
  input  logic [1:0]            cmd_sel,
  input  logic                  cmd_cin,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_result,
  output logic                  rsp_cout,
  output logic                  busy,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [1:0]            alu_sel,
  output logic                  alu_cin,
  input  logic [7:0]            alu_result,
  input  logic                  alu_cout
);

  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     state_r;
  state_t                     state_s;
  logic [CW-1:0]              idx_r;
  logic [NBYTES-1:0][7:0]     a_r;
  logic [NBYTES-1:0][7:0]     b_r;
  logic [NBYTES-1:0][7:0]     result_r;
  logic [1:0]                 sel_r;
  logic                       cin_r;
  logic                       carry_r;

  // Next-state selection; cmd_valid outside IDLE and rsp_ready outside DONE are ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid) state_s = RUN;
        else           state_s = IDLE;
      end
      RUN: begin
        if (idx_r == LAST_IDX) state_s = DONE;
        else                   state_s = RUN;
      end
      DONE: begin
        if (rsp_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode; the ALU is only driven while a byte is being processed.
  always_comb begin
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    rsp_valid  = 1'b0;
    rsp_result = {(8*NBYTES){1'b0}};
    rsp_cout   = 1'b0;
    alu_a      = 8'd0;
    alu_b      = 8'd0;
    alu_sel    = 2'd0;
    alu_cin    = 1'b0;
    case (state_r)
      IDLE: cmd_ready = 1'b1;
      RUN: begin
        busy    = 1'b1;
        alu_a   = a_r[idx_r];
        alu_b   = b_r[idx_r];
        alu_sel = sel_r;
        alu_cin = (idx_r == {CW{1'b0}}) ? cin_r : carry_r;
      end
      DONE: begin
        busy       = 1'b1;
        rsp_valid  = 1'b1;
        rsp_result = result_r;
        rsp_cout   = carry_r;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  // State, operand latch and per-byte result/carry capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      idx_r    <= {CW{1'b0}};
      a_r      <= {(8*NBYTES){1'b0}};
      b_r      <= {(8*NBYTES){1'b0}};
      result_r <= {(8*NBYTES){1'b0}};
      sel_r    <= 2'd0;
      cin_r    <= 1'b0;
      carry_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            a_r      <= cmd_a;
            b_r      <= cmd_b;
            sel_r    <= cmd_sel;
            cin_r    <= cmd_cin;
            result_r <= {(8*NBYTES){1'b0}};
            idx_r    <= {CW{1'b0}};
          end
        end
        RUN: begin
          result_r[idx_r] <= alu_result;
          carry_r         <= alu_cout;
          if (idx_r != LAST_IDX) idx_r <= idx_r + CW'(1);
        end
        DONE: begin
          idx_r <= idx_r;
        end
        default: idx_r <= {CW{1'b0}};
      endcase
    end
  end

endmodule
